// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill level, almost-full/almost-empty
// watermarks and sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       w_en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       r_en,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("sync_fifo_param: DEPTH must be a power of two >= 2");
        end
        if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
            $error("sync_fifo_param: AF_THRESH must be in 1..DEPTH");
        end
        if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
            $error("sync_fifo_param: AE_THRESH must be in 0..DEPTH-1");
        end
    endgenerate

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,    rd_ptr_d;
    logic [CW-1:0]    count_q,     count_d;
    logic [WIDTH-1:0] data_out_q,  data_out_d;
    logic             overflow_q,  overflow_d;
    logic             underflow_q, underflow_d;

    logic wr_acc;
    logic rd_acc;

    // Status decodes only from registered count, so no input reaches an output.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

    assign wr_acc = w_en && !full;
    assign rd_acc = r_en && !empty;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            data_out_d = mem_q[rd_ptr_q];
        end

        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end

        // Clear first so a coinciding error event wins.
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (w_en && full) begin
            overflow_d = 1'b1;
        end
        if (r_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out  = data_out_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=8, AF=6, AE=2).
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             w_en;
    logic [WIDTH-1:0] data_in;
    logic             r_en;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
    logic             err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    sync_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(6), .AE_THRESH(2)
    ) dut (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, release them 1ns later.
    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r,
                        input logic clr = 1'b0, input logic rs = 1'b0);
        w_en = w; data_in = d; r_en = r; err_clr = clr; rst = rs;
        @(posedge clk);
        #1;
        w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; rst = 1'b0;
    endtask

    initial begin
        w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; data_in = '0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step(1'b0, 8'h00, 1'b0);

        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_aempty", int'(almost_empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_afull", int'(almost_full), 0);
        check("rst_dout", int'(data_out), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_unf", int'(underflow), 0);

        // Fill 0x01..0x08, watching the watermarks cross.
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 8'(k), 1'b0);
            check("fill_count", int'(count), k);
            check("fill_aempty", int'(almost_empty), (k <= 2) ? 1 : 0);
            check("fill_afull", int'(almost_full), (k >= 6) ? 1 : 0);
            check("fill_full", int'(full), (k == 8) ? 1 : 0);
        end
        step(1'b1, 8'hFF, 1'b0);
        check("ovf_set", int'(overflow), 1);
        check("ovf_count", int'(count), 8);
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 8'h00, 1'b1);
            check("drain_data", int'(data_out), k);
        end
        check("drain_empty", int'(empty), 1);
        check("drain_ovf_sticky", int'(overflow), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr_ovf", int'(overflow), 0);

        // Pointer wrap.
        for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h10 + k), 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 8'h00, 1'b1);
            check("wrap_pre_data", int'(data_out), 8'h10 + k);
        end
        for (int k = 0; k < 8; k++) step(1'b1, 8'(8'hA0 + k), 1'b0);
        check("wrap_full", int'(full), 1);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 8'h00, 1'b1);
            check("wrap_data", int'(data_out), 8'hA0 + k);
        end
        check("wrap_empty", int'(empty), 1);

        // Streaming at count=4.
        for (int k = 0; k < 4; k++) step(1'b1, 8'(8'h30 + k), 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 8'(8'h34 + k), 1'b1);
            check("stream_count", int'(count), 4);
            check("stream_data", int'(data_out), 8'h30 + k);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 8'h00, 1'b1);
            check("stream_tail", int'(data_out), 8'h3A + k);
        end

        // Simultaneous while full.
        for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h50 + k), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        check("simfull_count", int'(count), 7);
        check("simfull_ovf", int'(overflow), 1);
        check("simfull_data", int'(data_out), 8'h50);
        for (int k = 1; k < 8; k++) begin
            step(1'b0, 8'h00, 1'b1);
            check("simfull_drain", int'(data_out), 8'h50 + k);
        end
        check("simfull_empty", int'(empty), 1);

        // Simultaneous while empty.
        step(1'b1, 8'h77, 1'b1);
        check("simempty_count", int'(count), 1);
        check("simempty_unf", int'(underflow), 1);
        check("simempty_hold", int'(data_out), 8'h57);
        step(1'b0, 8'h00, 1'b1);
        check("simempty_read", int'(data_out), 8'h77);

        // Error clear, and set-wins against clear.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr2_ovf", int'(overflow), 0);
        check("clr2_unf", int'(underflow), 0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check("setwins_unf", int'(underflow), 1);
        check("setwins_ovf", int'(overflow), 0);

        // Reset mid-operation overrides a write.
        for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h60 + k), 1'b0);
        check("pre_rst_count", int'(count), 5);
        step(1'b1, 8'hCC, 1'b0, 1'b0, 1'b1);
        check("midrst_count", int'(count), 0);
        check("midrst_empty", int'(empty), 1);
        check("midrst_unf", int'(underflow), 0);
        check("midrst_dout", int'(data_out), 0);
        step(1'b1, 8'h99, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("post_rst_data", int'(data_out), 8'h99);
        check("post_rst_empty", int'(empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
